// File: rtl/rom_pattern_loader_pkg.sv
// Shared types and defaults for the boot-time ROM pattern loader.
package rom_pattern_loader_pkg;

  typedef enum logic [1:0] {
    MODE_ALT  = 2'd0,
    MODE_INC  = 2'd1,
    MODE_FILL = 2'd2,
    MODE_WALK = 2'd3
  } mode_e;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StStart   = 3'd1;
  localparam state_t StReq     = 3'd2;
  localparam state_t StWaitAck = 3'd3;
  localparam state_t StWaitRel = 3'd4;
  localparam state_t StDone    = 3'd5;
  localparam state_t StErr     = 3'd6;

  localparam logic [15:0] DefaultHeaderWord = 16'hEA87;

  // States in which a session owns the loader port.
  function automatic logic is_active(state_t s);
    return (s == StStart) || (s == StReq) || (s == StWaitAck) || (s == StWaitRel);
  endfunction

endpackage

// File: rtl/rom_pattern_loader_if.sv
// ROM loader port: 4-phase sck/ack handshake carrying one word per request.
interface rom_pattern_loader_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic                  load;
  logic [DATA_WIDTH-1:0] data;
  logic                  sck;
  logic                  ack;

  modport master (
    output load,
    output data,
    output sck,
    input  ack
  );

  modport slave (
    input  load,
    input  data,
    input  sck,
    output ack
  );

endinterface

// File: rtl/rom_pattern_gen.sv
// Combinational test-pattern source: (mode, index, count) -> ROM word.
module rom_pattern_gen
  import rom_pattern_loader_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           CW          = 16,
  parameter logic [DATA_WIDTH-1:0] HEADER_WORD = DATA_WIDTH'(DefaultHeaderWord),
  parameter logic [DATA_WIDTH-1:0] FILL_WORD   = '0
) (
  input  mode_e                 mode_i,
  input  logic [CW-1:0]         index_i,
  input  logic [CW-1:0]         count_i,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam logic [DATA_WIDTH-1:0] OneHot0 = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    word_o = '0;
    unique case (mode_i)
      MODE_ALT: begin
        // Parity of (count - index) is just the XOR of the two LSBs.
        if (index_i == '0) begin
          word_o = HEADER_WORD;
        end else if (count_i[0] ^ index_i[0]) begin
          word_o = '1;
        end else begin
          word_o = '0;
        end
      end
      MODE_INC:  word_o = DATA_WIDTH'(index_i);
      MODE_FILL: word_o = FILL_WORD;
      MODE_WALK: word_o = OneHot0 << (index_i % CW'(DATA_WIDTH));
    endcase
  end

endmodule

// File: rtl/rom_pattern_loader.sv
// Streams a selectable test pattern into the ROM loader over a 4-phase handshake.
// Optional ROM_LOADER_CHECKSUM_EN adds a running XOR of acknowledged words.
module rom_pattern_loader
  import rom_pattern_loader_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           MAX_WORDS   = 32768,
  parameter logic [DATA_WIDTH-1:0] HEADER_WORD = DATA_WIDTH'(DefaultHeaderWord),
  parameter logic [DATA_WIDTH-1:0] FILL_WORD   = '0,
  parameter int unsigned           ACK_TIMEOUT = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               run,
  input  logic [1:0]                         mode,
  input  logic [$clog2(MAX_WORDS+1)-1:0]     word_count,
  output logic                               busy,
  output logic                               done_loading,
  output logic                               timeout_err,
`ifdef ROM_LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]              checksum,
`endif
  rom_pattern_loader_if.master               rom_loader
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  state_t                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         index_q, index_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  was_run_q;
  logic                  active_q, active_d;
  logic                  sck_q, sck_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] gen_word;
  logic                  run_rise;
  logic                  timer_last;
  logic                  start_go;

  assign run_rise   = run & ~was_run_q;
  assign timer_last = (timer_q == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    index_d  = index_q;
    done_d   = done_q;
    err_d    = err_q;
    start_go = 1'b0;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (run_rise) begin
          start_go = 1'b1;
          state_d  = StStart;
          mode_d   = mode_e'(mode);
          count_d  = (word_count > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : word_count;
          index_d  = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      StStart: state_d = (count_q == '0) ? StDone : StReq;
      StReq:   state_d = StWaitAck;
      StWaitAck: begin
        // A same-cycle ack beats the timeout.
        if (rom_loader.ack) begin
          state_d = StWaitRel;
        end else if (timer_last) begin
          state_d = StErr;
        end
      end
      StWaitRel: begin
        if (!rom_loader.ack) begin
          index_d = index_q + CW'(1);
          state_d = (index_d == count_q) ? StDone : StReq;
        end else if (timer_last) begin
          state_d = StErr;
        end
      end
      default: state_d = StIdle;
    endcase

    if (is_active(state_q) && !run) begin
      state_d = StIdle;
      index_d = '0;
    end

    if (state_d == StDone && state_q != StDone) done_d = 1'b1;
    if (state_d == StErr) err_d = 1'b1;

    active_d = is_active(state_d);
    sck_d    = (state_d == StReq) || (state_d == StWaitAck);

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_last) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  rom_pattern_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CW          (CW),
    .HEADER_WORD (HEADER_WORD),
    .FILL_WORD   (FILL_WORD)
  ) u_gen (
    .mode_i  (mode_q),
    .index_i (index_d),
    .count_i (count_q),
    .word_o  (gen_word)
  );

  // Data is captured on REQ entry so it launches together with sck.
  always_comb begin
    data_d = data_q;
    if (state_d == StReq && state_q != StReq) data_d = gen_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mode_q    <= MODE_ALT;
      count_q   <= '0;
      index_q   <= '0;
      timer_q   <= '0;
      was_run_q <= 1'b0;
      active_q  <= 1'b0;
      sck_q     <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      index_q   <= index_d;
      timer_q   <= timer_d;
      was_run_q <= run;
      active_q  <= active_d;
      sck_q     <= sck_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_go) begin
      csum_d = '0;
    end else if (state_q == StWaitAck && state_d == StWaitRel) begin
      csum_d = csum_q ^ data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

  assign busy            = active_q;
  assign done_loading    = done_q;
  assign timeout_err     = err_q;
  assign rom_loader.load = active_q;
  assign rom_loader.sck  = sck_q;
  assign rom_loader.data = data_q;

endmodule

// File: tb/tb_rom_pattern_loader.sv
// Directed bench for rom_pattern_loader; ack is sck delayed by a selectable number of cycles.
module tb_rom_pattern_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [1:0]  mode;
  logic [15:0] word_count;
  logic        busy;
  logic        done_loading;
  logic        timeout_err;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  rom_pattern_loader_if #(.DATA_WIDTH(16)) rom_if ();

  rom_pattern_loader #(
    .DATA_WIDTH  (16),
    .MAX_WORDS   (32768),
    .HEADER_WORD (16'hEA87),
    .FILL_WORD   (16'hA5A5),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .mode         (mode),
    .word_count   (word_count),
    .busy         (busy),
    .done_loading (done_loading),
    .timeout_err  (timeout_err),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .rom_loader   (rom_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  sck_hist = '0;
  logic [2:0]  ack_sel  = '0;
  logic        ack_en   = 1'b0;
  logic [15:0] cap_q[$];
  logic        sck_prev  = 1'b0;
  logic [15:0] data_prev = '0;
  int          stab_err  = 0;

  assign rom_if.ack = ack_en & sck_hist[ack_sel];

  // Loader model plus a capture of each word at its sck rise.
  always @(posedge clk) begin
    sck_hist <= {sck_hist[6:0], rom_if.sck};
    if (rom_if.sck && !sck_prev) cap_q.push_back(rom_if.data);
    if (rom_if.sck && sck_prev && rom_if.data != data_prev) stab_err = stab_err + 1;
    sck_prev  <= rom_if.sck;
    data_prev <= rom_if.data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cap(input string tag, input int i, input logic [15:0] exp);
    logic [31:0] got;
    got = (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hDEAD_BEEF;
    check_eq($sformatf("%s_w%0d", tag, i), got, 32'(exp));
  endtask

  // Returns just after the edge that samples the run rise.
  task automatic start_run(input logic [1:0] m, input logic [15:0] cnt);
    run = 1'b0;
    tick(1);
    mode       = m;
    word_count = cnt;
    cap_q.delete();
    stab_err = 0;
    run = 1'b1;
    tick(1);
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_loading !== 1'b1 && n < max_cyc) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    run        = 1'b0;
    mode       = 2'd0;
    word_count = '0;
    tick(3);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done_loading), 32'd0);
    check_eq("rst_err", 32'(timeout_err), 32'd0);
    check_eq("rst_load", 32'(rom_if.load), 32'd0);
    check_eq("rst_sck", 32'(rom_if.sck), 32'd0);
    check_eq("rst_data", 32'(rom_if.data), 32'd0);
    reset = 1'b0;
    tick(1);

    // ALT, count 4, one-cycle ack: done appears on the 17th edge after the rise edge.
    ack_en  = 1'b1;
    ack_sel = 3'd0;
    start_run(2'd0, 16'd4);
    check_eq("t1_busy_start", 32'(busy), 32'd1);
    tick(16);
    check_eq("t1_done_early", 32'(done_loading), 32'd0);
    tick(1);
    check_eq("t1_done", 32'(done_loading), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_load", 32'(rom_if.load), 32'd0);
    check_eq("t1_nwords", cap_q.size(), 32'd4);
    check_cap("t1", 0, 16'hEA87);
    check_cap("t1", 1, 16'hFFFF);
    check_cap("t1", 2, 16'h0000);
    check_cap("t1", 3, 16'hFFFF);
    run = 1'b0;
    tick(1);
    check_eq("t1_done_held", 32'(done_loading), 32'd1);

    // ALT with an odd count flips the parity of the tail.
    start_run(2'd0, 16'd3);
    wait_done(40);
    check_eq("t1b_done", 32'(done_loading), 32'd1);
    check_cap("t1b", 0, 16'hEA87);
    check_cap("t1b", 1, 16'h0000);
    check_cap("t1b", 2, 16'hFFFF);

    // INC, count 3, ack delayed 5 cycles; data must hold while sck is high.
    ack_sel = 3'd4;
    start_run(2'd1, 16'd3);
    wait_done(100);
    check_eq("t2_done", 32'(done_loading), 32'd1);
    check_eq("t2_nwords", cap_q.size(), 32'd3);
    check_cap("t2", 0, 16'h0000);
    check_cap("t2", 1, 16'h0001);
    check_cap("t2", 2, 16'h0002);
    check_eq("t2_stable", stab_err, 32'd0);
    check_eq("t2_err", 32'(timeout_err), 32'd0);

    // Zero count: load pulses for the START cycle only.
    ack_sel = 3'd0;
    start_run(2'd0, 16'd0);
    check_eq("t3_load_pulse", 32'(rom_if.load), 32'd1);
    check_eq("t3_done_early", 32'(done_loading), 32'd0);
    tick(1);
    check_eq("t3_load_off", 32'(rom_if.load), 32'd0);
    check_eq("t3_done", 32'(done_loading), 32'd1);
    tick(2);
    check_eq("t3_no_sck", cap_q.size(), 32'd0);

    // No ack: error after 8 cycles in WAIT_ACK.
    ack_en = 1'b0;
    start_run(2'd0, 16'd4);
    tick(9);
    check_eq("t4_err_early", 32'(timeout_err), 32'd0);
    check_eq("t4_sck_wait", 32'(rom_if.sck), 32'd1);
    tick(1);
    check_eq("t4_err", 32'(timeout_err), 32'd1);
    check_eq("t4_load", 32'(rom_if.load), 32'd0);
    check_eq("t4_sck", 32'(rom_if.sck), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd0);
    start_run(2'd0, 16'd4);
    check_eq("t4_err_clr", 32'(timeout_err), 32'd0);
    check_eq("t4_rerun_busy", 32'(busy), 32'd1);
    run = 1'b0;
    tick(1);
    check_eq("t4_abort_busy", 32'(busy), 32'd0);

    // WALK, count 20, abort after word 5, then a full rerun from index 0.
    ack_en  = 1'b1;
    ack_sel = 3'd0;
    start_run(2'd3, 16'd20);
    for (int n = 0; n < 100 && cap_q.size() < 6; n++) tick(1);
    check_eq("t5_reached_w5", cap_q.size(), 32'd6);
    run = 1'b0;
    tick(1);
    check_eq("t5_abort_load", 32'(rom_if.load), 32'd0);
    check_eq("t5_abort_busy", 32'(busy), 32'd0);
    check_eq("t5_abort_done", 32'(done_loading), 32'd0);
    check_eq("t5_abort_sck", 32'(rom_if.sck), 32'd0);
    for (int i = 0; i < 6; i++) check_cap("t5", i, 16'h0001 << i);
    start_run(2'd3, 16'd20);
    wait_done(200);
    check_eq("t5_rerun_done", 32'(done_loading), 32'd1);
    check_eq("t5_rerun_nwords", cap_q.size(), 32'd20);
    check_cap("t5r", 0, 16'h0001);
    check_cap("t5r", 15, 16'h8000);
    check_cap("t5r", 16, 16'h0001);
    check_cap("t5r", 19, 16'h0008);

    // FILL words; checksum when built in.
    start_run(2'd2, 16'd3);
    wait_done(60);
    check_eq("t6_done", 32'(done_loading), 32'd1);
    check_cap("t6", 0, 16'hA5A5);
    check_cap("t6", 2, 16'hA5A5);
`ifdef ROM_LOADER_CHECKSUM_EN
    check_eq("t6_csum3", 32'(checksum), 32'h0000_A5A5);
`endif
    start_run(2'd2, 16'd2);
    wait_done(60);
    check_eq("t6b_done", 32'(done_loading), 32'd1);
    check_eq("t6b_nwords", cap_q.size(), 32'd2);
`ifdef ROM_LOADER_CHECKSUM_EN
    check_eq("t6_csum2", 32'(checksum), 32'h0000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
